// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR sequencer: circular delay line, coefficient RAM and an
// accumulator around an external zero-latency signed multiplier.
module fir_tap_sequencer #(
    parameter int TAPS = 8,
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int ACCW = 19
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_sample,
    input  logic            coef_we,
    input  logic [AW-1:0]   coef_addr,
    input  logic [DW-1:0]   coef_data,
    output logic [DW-1:0]   mult_md,
    output logic [DW-1:0]   mult_m,
    input  logic [2*DW-1:0] mult_p,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_data,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]             state;
    logic [AW-1:0]          k;
    logic [AW-1:0]          wp;
    logic [AW-1:0]          rd_idx;
    logic signed [DW-1:0]   dline [TAPS];
    logic signed [DW-1:0]   coef  [TAPS];
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] sum;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // x[k] lives k slots behind the write pointer; AW-bit wrap gives mod TAPS.
    assign rd_idx   = wp - k;
    assign prod_ext = ACCW'($signed(mult_p));
    assign sum      = ((k == '0) ? '0 : acc) + prod_ext;

    always_comb begin
        mult_md = '0;
        mult_m  = '0;
        if (state == S_MAC) begin
            mult_md = dline[rd_idx];
            mult_m  = coef[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            k         <= '0;
            wp        <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (coef_we) begin
                        coef[coef_addr] <= coef_data;
                    end
                    if (in_valid) begin
                        dline[wp + AW'(1)] <= in_sample;
                        wp                 <= wp + AW'(1);
                        k                  <= '0;
                        state              <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= sum;
                    k   <= k + AW'(1);
                    if (k == AW'(TAPS - 1)) begin
                        out_data  <= sum;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: directed literal cases plus randomized traffic,
// all checked every cycle against a sample-history / dot-product model.
module tb_fir_tap_sequencer;

    localparam int TAPS = 8;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int ACCW = 19;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_sample;
    logic            coef_we;
    logic [AW-1:0]   coef_addr;
    logic [DW-1:0]   coef_data;
    logic [DW-1:0]   mult_md;
    logic [DW-1:0]   mult_m;
    logic [2*DW-1:0] mult_p;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_data;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // Model: phase 0 idle, 1 computing (m_k taps done), 2 result pending.
    int m_state = 0;
    int m_k     = 0;
    int m_y     = 0;
    int hist  [TAPS];
    int coefm [TAPS];

    fir_tap_sequencer #(.TAPS(TAPS), .DW(DW), .AW(AW), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .mult_md(mult_md), .mult_m(mult_m), .mult_p(mult_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    assign mult_p = 16'(int'($signed(mult_md)) * int'($signed(mult_m)));

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_k     = 0;
            m_y     = 0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i]  = 0;
                coefm[i] = 0;
            end
        end else begin
            case (m_state)
                0: begin
                    if (coef_we) coefm[coef_addr] = int'($signed(coef_data));
                    if (in_valid) begin
                        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
                        hist[0] = int'($signed(in_sample));
                        m_y = 0;
                        for (int i = 0; i < TAPS; i++) m_y += coefm[i] * hist[i];
                        m_state = 1;
                        m_k     = 0;
                    end
                end
                1: begin
                    m_k++;
                    if (m_k == TAPS) m_state = 2;
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", in_ready, m_state == 0);
            chk("busy", busy, m_state != 0);
            chk("out_valid", out_valid, m_state == 2);
            if (m_state == 2) chk("out_data", longint'($signed(out_data)), m_y);
            if (m_state == 1) begin
                chk("mult_md", longint'($signed(mult_md)), hist[m_k]);
                chk("mult_m", longint'($signed(mult_m)), coefm[m_k]);
            end else begin
                chk("mult_md_zero", mult_md, 0);
                chk("mult_m_zero", mult_m, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_coef(input int a, input logic [DW-1:0] d);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] s);
        bit ok = 1'b0;
        in_valid  = 1'b1;
        in_sample = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        coef_we  = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic recv(output logic signed [ACCW-1:0] v, input int hold);
        bit got = 1'b0;
        v = '0;
        out_ready = 1'b0;
        repeat (hold) tick();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                v   = out_data;
            end
            @(posedge clk);
            #1;
        end
        chk("recv_done", got, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [ACCW-1:0] v;
        logic signed [ACCW-1:0] held;
        bit seen;

        rst = 1'b1; in_valid = 1'b0; in_sample = '0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; out_ready = 1'b1;
        do_reset();
        mon_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_data", longint'($signed(out_data)), 0);
        chk("rst_in_ready", in_ready, 1);
        tick();

        // Impulse response through coef[k]=k+1
        for (int k = 0; k < TAPS; k++) write_coef(k, DW'(k + 1));
        send(8'd1);
        recv(v, 0);
        chk("impulse_0", v, 1);
        for (int k = 1; k < TAPS; k++) begin
            send(8'd0);
            recv(v, 0);
            chk($sformatf("impulse_%0d", k), v, k + 1);
        end
        send(8'd0);
        recv(v, 0);
        chk("impulse_tail", v, 0);

        // Extreme magnitude
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 8'h80);
        for (int n = 1; n <= TAPS; n++) begin
            send(8'h80);
            recv(v, 0);
            chk($sformatf("extreme_%0d", n), v, n * 16384);
        end
        chk("extreme_final", v, 131072);
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 8'h80);
        send(8'h7F);
        recv(v, 0);
        chk("pos127_neg128", v, -16256);

        // Latency: x = {2, 127}, all coef -128
        out_ready = 1'b1;
        send(8'd2);
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clk);
            chk("lat_out_valid_low", out_valid, 0);
            chk("lat_in_ready_low", in_ready, 0);
        end
        @(negedge clk);
        chk("lat_out_valid_high", out_valid, 1);
        chk("lat_in_ready_still_low", in_ready, 0);
        chk("lat_value", longint'($signed(out_data)), -16512);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_in_ready_back", in_ready, 1);
        chk("lat_out_valid_dropped", out_valid, 0);
        tick();

        // Backpressure: x = {1, 2, 127}
        out_ready = 1'b0;
        send(8'd1);
        seen = 1'b0;
        held = '0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                held = out_data;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_seen", seen, 1);
        chk("bp_value", held, -16640);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid  = 1'b1;
                in_sample = 8'h55;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("bp_valid_held", out_valid, 1);
            chk("bp_data_held", longint'($signed(out_data)), held);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        send(8'd0);
        recv(v, 0);
        chk("bp_not_consumed", v, -16640);

        // Coefficient write gating
        do_reset();
        write_coef(0, 8'd2);
        send(8'd3);
        coef_we = 1'b1; coef_addr = '0; coef_data = 8'h7F;
        tick();
        coef_we = 1'b0;
        recv(v, 0);
        chk("coef_mac_ignored", v, 6);
        send(8'd5);
        recv(v, 0);
        chk("coef_still_old", v, 10);
        coef_we = 1'b1; coef_addr = '0; coef_data = 8'h7F;
        send(8'd1);
        recv(v, 0);
        chk("coef_concurrent_used", v, 127);

        // Reset in the middle of MAC
        for (int k = 0; k < TAPS; k++) write_coef(k, DW'(k + 1));
        send(8'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        tick();
        send(8'd1);
        recv(v, 0);
        chk("midrst_zero_coefs", v, 0);

        // Randomized traffic with noise during computation
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 2) == 0) write_coef(int'($urandom_range(0, TAPS - 1)), DW'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                coef_we   = 1'b1;
                coef_addr = AW'($urandom);
                coef_data = DW'($urandom);
            end
            send(DW'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                coef_we   = 1'b1;
                coef_addr = AW'($urandom);
                coef_data = DW'($urandom);
                in_valid  = 1'b1;
                in_sample = DW'($urandom);
                tick();
                coef_we  = 1'b0;
                in_valid = 1'b0;
            end
            recv(v, int'($urandom_range(0, 4)));
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
